// File: rtl/rosc_odometer_meas_ctrl_pkg.sv
// Shared FSM encoding and default geometry for the ring-oscillator odometer
// measurement controller and its edge-counting datapath.
package rosc_odometer_meas_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_STRESS  = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_MEASURE = 3'd3,
    ST_FINISH  = 3'd4
  } state_t;

  localparam int DEF_N_ROSC     = 3;
  localparam int DEF_SEL_W      = 2;
  localparam int DEF_CNT_W      = 16;
  localparam int DEF_WIN_W      = 16;
  localparam int DEF_SETTLE_CYC = 8;

endpackage

// File: rtl/rosc_odometer_meas_ctrl_edge_counter.sv
// Synchroniser bank, channel select, rising-edge detect and saturating edge
// counter for the selected ring oscillator.
module rosc_edge_counter #(
  parameter int N_ROSC = 3,
  parameter int SEL_W  = 2,
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              CLR,
  input  logic              EN,
  input  logic [SEL_W-1:0]  SEL,
  input  logic [N_ROSC-1:0] ROSC_OUT,
  output logic [CNT_W-1:0]  CNT,
  output logic              OVF
);

  logic [N_ROSC-1:0] sync1_reg, sync2_reg;
  logic              sel_bit, prev_reg, rise;

  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
      prev_reg  <= 1'b0;
    end else begin
      sync1_reg <= ROSC_OUT;
      sync2_reg <= sync1_reg;
      // Tracks the selected bit every cycle, so it is already primed when the
      // last settle cycle clears the counter.
      prev_reg  <= sel_bit;
    end
  end

  always_comb begin
    sel_bit = 1'b0;
    for (int i = 0; i < N_ROSC; i++) begin
      if (SEL == SEL_W'(i)) sel_bit = sync2_reg[i];
    end
  end

  assign rise = sel_bit & ~prev_reg;

  // OVF flags an edge that arrived while the count was already at full scale.
  always_ff @(posedge CLK) begin
    if (RST || CLR) begin
      CNT <= '0;
      OVF <= 1'b0;
    end else if (EN && rise) begin
      if (&CNT) OVF <= 1'b1;
      else      CNT <= CNT + 1'b1;
    end
  end

endmodule

// File: rtl/rosc_odometer_meas_ctrl.sv
// Stress/measure sequencer for stacked ROSC odometer channels: power gating,
// settle timing, windowed edge counting and registered status outputs.
module rosc_odometer_meas_ctrl
  import rosc_odometer_meas_ctrl_pkg::*;
#(
  parameter int N_ROSC     = DEF_N_ROSC,
  parameter int SEL_W      = DEF_SEL_W,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int WIN_W      = DEF_WIN_W,
  parameter int SETTLE_CYC = DEF_SETTLE_CYC
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic              AC_DC,
  input  logic              MEAS_REQ,
  input  logic [SEL_W-1:0]  ROSC_SEL,
  input  logic [WIN_W-1:0]  WIN_LEN,
  input  logic [N_ROSC-1:0] ROSC_OUT,
  output logic [N_ROSC-1:0] PWR_EN,
  output logic [N_ROSC-1:0] EN_ROSC,
  output logic              MEAS_STRESS,
  output logic              STRESS_ACT,
  output logic              BUSY,
  output logic              DONE,
  output logic [CNT_W-1:0]  COUNT,
  output logic              OVF,
  output logic              SEL_ERR
);

  localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  state_t            state_reg, state_next;
  logic [SEL_W-1:0]  sel_reg, sel_next;
  logic [SET_W-1:0]  settle_cnt_reg;
  logic [WIN_W-1:0]  win_cnt_reg;
  logic              accept, sel_valid, sel_err_next;
  logic              cnt_clr, cnt_en, ovf_raw;
  logic [CNT_W-1:0]  cnt_raw;
  logic [N_ROSC-1:0] onehot_next, pwr_next, en_next;
  logic              meas_next, stress_next;
  logic              ac_dc_unused;

  // The stress mode only matters to the per-channel ROSC control block.
  assign ac_dc_unused = AC_DC;
  assign sel_valid    = 32'(ROSC_SEL) < 32'(N_ROSC);

  always_comb begin
    state_next   = state_reg;
    accept       = 1'b0;
    sel_err_next = 1'b0;
    case (state_reg)
      ST_IDLE, ST_STRESS: begin
        if (MEAS_REQ) begin
          if (sel_valid) begin
            state_next = ST_SETTLE;
            accept     = 1'b1;
          end else begin
            sel_err_next = 1'b1;
          end
        end else begin
          state_next = START ? ST_STRESS : ST_IDLE;
        end
      end
      ST_SETTLE:  if (settle_cnt_reg == '0) state_next = ST_MEASURE;
      ST_MEASURE: if (win_cnt_reg == '0) state_next = ST_FINISH;
      ST_FINISH:  state_next = START ? ST_STRESS : ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  assign sel_next = accept ? ROSC_SEL : sel_reg;

  genvar gi;
  generate
    for (gi = 0; gi < N_ROSC; gi++) begin : g_onehot
      assign onehot_next[gi] = (sel_next == SEL_W'(gi));
    end
  endgenerate

  // Output values are decoded from the next state so they line up with it.
  always_comb begin
    pwr_next    = '0;
    en_next     = '0;
    meas_next   = 1'b0;
    stress_next = 1'b0;
    case (state_next)
      ST_STRESS: begin
        pwr_next    = '1;
        stress_next = 1'b1;
      end
      ST_SETTLE, ST_MEASURE: begin
        pwr_next  = onehot_next;
        en_next   = onehot_next;
        meas_next = 1'b1;
      end
      default: ;
    endcase
  end

  assign cnt_clr = (state_reg == ST_SETTLE) && (settle_cnt_reg == '0);
  assign cnt_en  = (state_reg == ST_MEASURE);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg      <= ST_IDLE;
      sel_reg        <= '0;
      settle_cnt_reg <= '0;
      win_cnt_reg    <= '0;
      PWR_EN         <= '0;
      EN_ROSC        <= '0;
      MEAS_STRESS    <= 1'b0;
      STRESS_ACT     <= 1'b0;
      BUSY           <= 1'b0;
      DONE           <= 1'b0;
      COUNT          <= '0;
      OVF            <= 1'b0;
      SEL_ERR        <= 1'b0;
    end else begin
      state_reg <= state_next;
      sel_reg   <= sel_next;
      // A zero-length window is treated as one cycle.
      if (accept) begin
        settle_cnt_reg <= SET_W'(SETTLE_CYC - 1);
        win_cnt_reg    <= (WIN_LEN == '0) ? '0 : WIN_LEN - 1'b1;
      end else if (state_reg == ST_SETTLE) begin
        settle_cnt_reg <= settle_cnt_reg - 1'b1;
      end else if (state_reg == ST_MEASURE) begin
        win_cnt_reg <= win_cnt_reg - 1'b1;
      end
      PWR_EN      <= pwr_next;
      EN_ROSC     <= en_next;
      MEAS_STRESS <= meas_next;
      BUSY        <= meas_next;
      STRESS_ACT  <= stress_next;
      SEL_ERR     <= sel_err_next;
      DONE        <= (state_reg == ST_FINISH);
      if (state_reg == ST_FINISH) begin
        COUNT <= cnt_raw;
        OVF   <= ovf_raw;
      end
    end
  end

  rosc_edge_counter #(
    .N_ROSC(N_ROSC),
    .SEL_W (SEL_W),
    .CNT_W (CNT_W)
  ) u_edge_counter (
    .CLK     (CLK),
    .RST     (RST),
    .CLR     (cnt_clr),
    .EN      (cnt_en),
    .SEL     (sel_reg),
    .ROSC_OUT(ROSC_OUT),
    .CNT     (cnt_raw),
    .OVF     (ovf_raw)
  );

endmodule

// File: tb/tb_rosc_odometer_meas_ctrl.sv
// Directed scenarios plus randomized traffic for the ROSC odometer controller,
// checked every cycle against a timeline-based behavioural model.
module tb_rosc_odometer_meas_ctrl;

  localparam int N    = 3;
  localparam int S    = 8;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          ac_dc = 1'b0;
  logic          meas_req = 1'b0;
  logic [1:0]    rosc_sel = '0;
  logic [15:0]   win_len = '0;
  logic [N-1:0]  rosc = '0;

  logic [N-1:0]  PWR_EN, EN_ROSC;
  logic          MEAS_STRESS, STRESS_ACT, BUSY, DONE, OVF, SEL_ERR;
  logic [CW-1:0] COUNT;

  int checks = 0;
  int errors = 0;
  int done_count = 0;

  rosc_odometer_meas_ctrl #(
    .N_ROSC(N), .SEL_W(2), .CNT_W(CW), .WIN_W(16), .SETTLE_CYC(S)
  ) dut (
    .CLK(clk), .RST(rst), .START(start), .AC_DC(ac_dc), .MEAS_REQ(meas_req),
    .ROSC_SEL(rosc_sel), .WIN_LEN(win_len), .ROSC_OUT(rosc),
    .PWR_EN(PWR_EN), .EN_ROSC(EN_ROSC), .MEAS_STRESS(MEAS_STRESS),
    .STRESS_ACT(STRESS_ACT), .BUSY(BUSY), .DONE(DONE), .COUNT(COUNT),
    .OVF(OVF), .SEL_ERR(SEL_ERR)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // ROSC source: per-channel toggle every half_per cycles, or random bits when 0.
  int half_per [N];
  int ph [N];
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (half_per[i] == 0) rosc[i] = 1'($urandom);
      else begin
        ph[i]++;
        if (ph[i] >= half_per[i]) begin
          ph[i]   = 0;
          rosc[i] = ~rosc[i];
        end
      end
    end
  end

  // Model: a measurement accepted at clock edge k is in settle for edges
  // k..k+S-1 after it, measures for W edges, finishes for one, and reports
  // at edge k+S+W+1. Input samples k+S-1..k+S+W-2 feed the count (two-flop
  // synchroniser plus edge detect delay).
  logic [N-1:0] hist [65536];
  int     edge_no = 0;
  int     k = 0, m_w = 1, el = 0, total = 0;
  logic [1:0] m_sel = '0;
  bit     in_meas = 0, m_stress = 0;
  int     m_count = 0;
  bit     m_ovf = 0, m_done = 0, m_sel_err = 0, m_busy = 0, m_stress_act = 0;
  logic [N-1:0] m_pwr = '0, m_en = '0;

  always @(posedge clk) begin
    edge_no++;
    hist[edge_no % 65536] = rosc;
    m_done    = 0;
    m_sel_err = 0;
    if (rst) begin
      in_meas  = 0;
      m_stress = 0;
      m_count  = 0;
      m_ovf    = 0;
    end else if (in_meas) begin
      if (edge_no - k == S + m_w + 1) begin
        total = 0;
        for (int j = k + S - 1; j <= k + S + m_w - 2; j++)
          if (hist[j % 65536][m_sel] && !hist[(j - 1) % 65536][m_sel]) total++;
        m_count  = (total > CMAX) ? CMAX : total;
        m_ovf    = (total > CMAX);
        m_done   = 1;
        in_meas  = 0;
        m_stress = start;
      end
    end else if (meas_req) begin
      if (rosc_sel >= N) m_sel_err = 1;
      else begin
        in_meas = 1;
        k       = edge_no;
        m_sel   = rosc_sel;
        m_w     = (win_len == 0) ? 1 : int'(win_len);
      end
    end else begin
      m_stress = start;
    end
    el = edge_no - k;
    if (in_meas && el < S + m_w) begin
      m_pwr = N'(1) << m_sel; m_en = N'(1) << m_sel; m_busy = 1; m_stress_act = 0;
    end else if (in_meas) begin
      m_pwr = '0; m_en = '0; m_busy = 0; m_stress_act = 0;
    end else begin
      m_pwr = m_stress ? '1 : '0; m_en = '0; m_busy = 0; m_stress_act = m_stress;
    end
  end

  always @(negedge clk) begin
    if (edge_no > 0) begin
      chk("pwr_en",      32'(PWR_EN),      32'(m_pwr));
      chk("en_rosc",     32'(EN_ROSC),     32'(m_en));
      chk("meas_stress", 32'(MEAS_STRESS), 32'(m_busy));
      chk("busy",        32'(BUSY),        32'(m_busy));
      chk("stress_act",  32'(STRESS_ACT),  32'(m_stress_act));
      chk("done",        32'(DONE),        32'(m_done));
      chk("sel_err",     32'(SEL_ERR),     32'(m_sel_err));
      chk("count",       32'(COUNT),       32'(m_count));
      chk("ovf",         32'(OVF),         32'(m_ovf));
    end
    if (DONE === 1'b1) done_count++;
  end

  task automatic pulse_req(input logic [1:0] s, input logic [15:0] w);
    rosc_sel = s;
    win_len  = w;
    meas_req = 1'b1;
    @(negedge clk);
    meas_req = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int n);
    n = 0;
    while (DONE !== 1'b1 && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", 32'(DONE), 32'd1);
  endtask

  int n, dc0;

  initial begin
    half_per[0] = 0; half_per[1] = 5; half_per[2] = 4;
    for (int i = 0; i < N; i++) ph[i] = 0;

    // Reset and stress entry
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_pwr_en", 32'(PWR_EN), 32'd0);
    chk("rst_stress_act", 32'(STRESS_ACT), 32'd0);
    chk("rst_count", 32'(COUNT), 32'd0);
    rst = 1'b0;
    start = 1'b1;
    @(negedge clk);
    chk("stress_act_lit", 32'(STRESS_ACT), 32'd1);
    chk("stress_pwr_lit", 32'(PWR_EN), 32'h7);
    chk("stress_en_lit", 32'(EN_ROSC), 32'd0);

    // Basic measurement on channel 1, 10 rising edges per 100 cycles
    start = 1'b0;
    repeat (2) @(negedge clk);
    pulse_req(2'd1, 16'd100);
    repeat (4) @(negedge clk);
    chk("basic_en_rosc", 32'(EN_ROSC), 32'h2);
    chk("basic_pwr_en", 32'(PWR_EN), 32'h2);
    wait_done(400, n);
    chk("basic_latency", 32'(1 + 4 + n), 32'd110);
    chk("basic_count_pm1", 32'(COUNT >= 9 && COUNT <= 11), 32'd1);
    chk("basic_ovf", 32'(OVF), 32'd0);

    // Saturation: 25 edges into a 4-bit counter
    repeat (3) @(negedge clk);
    pulse_req(2'd2, 16'd200);
    wait_done(400, n);
    chk("sat_count", 32'(COUNT), 32'd15);
    chk("sat_ovf", 32'(OVF), 32'd1);

    // Invalid select, then a dropped request while busy
    repeat (3) @(negedge clk);
    pulse_req(2'd3, 16'd10);
    chk("sel_err_lit", 32'(SEL_ERR), 32'd1);
    chk("sel_err_busy", 32'(BUSY), 32'd0);
    dc0 = done_count;
    pulse_req(2'd0, 16'd20);
    repeat (3) @(negedge clk);
    pulse_req(2'd1, 16'd5);
    wait_done(400, n);
    repeat (60) @(negedge clk);
    chk("single_done", 32'(done_count - dc0), 32'd1);

    // Stress interleave: START dropped mid-measure, then held
    start = 1'b1;
    @(negedge clk);
    pulse_req(2'd0, 16'd30);
    repeat (15) @(negedge clk);
    start = 1'b0;
    wait_done(400, n);
    chk("ilv_idle_pwr", 32'(PWR_EN), 32'd0);
    chk("ilv_idle_stress", 32'(STRESS_ACT), 32'd0);
    start = 1'b1;
    repeat (3) @(negedge clk);
    pulse_req(2'd2, 16'd30);
    wait_done(400, n);
    chk("ilv_stress_pwr", 32'(PWR_EN), 32'h7);
    chk("ilv_stress_act", 32'(STRESS_ACT), 32'd1);

    // Reset during measure
    start = 1'b0;
    repeat (3) @(negedge clk);
    pulse_req(2'd1, 16'd100);
    repeat (30) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstmid_count", 32'(COUNT), 32'd0);
    chk("rstmid_done", 32'(DONE), 32'd0);
    chk("rstmid_busy", 32'(BUSY), 32'd0);
    chk("rstmid_pwr", 32'(PWR_EN), 32'd0);
    dc0 = done_count;
    repeat (150) @(negedge clk);
    chk("rstmid_no_done", 32'(done_count - dc0), 32'd0);

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      if (c % 500 == 0)
        for (int i = 0; i < N; i++) half_per[i] = $urandom_range(0, 6);
      rst      = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 29) == 0) start = ~start;
      meas_req = ($urandom_range(0, 9) == 0);
      rosc_sel = 2'($urandom_range(0, 3));
      win_len  = 16'($urandom_range(0, 40));
      ac_dc    = 1'($urandom);
      @(negedge clk);
    end
    rst = 1'b0;
    meas_req = 1'b0;
    repeat (100) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
